// File: rtl/fifo_stream_checker.sv
// fifo_stream_checker: in-line golden model and scoreboard for a synchronous FIFO.
// Define FIFO_CHK_FIRST_ERR_EN to add first-mismatch capture outputs and a scored-cycle counter.
module fifo_stream_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic                  dut_rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  almostfull,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  wr_ack,
  input  logic                  test_done,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  err_valid,
  output logic [7:0]            err_flags,
  output logic                  done,
`ifdef FIFO_CHK_FIRST_ERR_EN
  output logic [CNT_WIDTH-1:0]  first_err_cycle,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_act,
  output logic [7:0]            first_err_flags,
  output logic                  first_err_valid,
`endif
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wp, rp;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] exp_data_out;
  logic                  exp_wr_ack, exp_overflow, exp_underflow;

  logic       model_en, wr_acc, rd_acc, scored;
  logic [7:0] mismatch;

  assign model_en = (state != DONE);
  assign wr_acc   = wr_en && (count < DEPTH_C);
  assign rd_acc   = rd_en && (count != '0);
  assign scored   = (state == RUN) && sample_en && dut_rst_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mismatch    = '0;
    mismatch[0] = (data_out != exp_data_out);
    mismatch[1] = (full != (count == DEPTH_C));
    mismatch[2] = (almostfull != (count == DEPTH_C - CNT_W'(1)));
    mismatch[3] = (empty != (count == '0));
    mismatch[4] = (almostempty != (count == CNT_W'(1)));
    mismatch[5] = (overflow != exp_overflow);
    mismatch[6] = (underflow != exp_underflow);
    mismatch[7] = (wr_ack != exp_wr_ack);
  end

  // NOTE: the shadow memory has no reset; count=0 guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (model_en && dut_rst_n && wr_acc) mem[wp] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      exp_data_out  <= '0;
      exp_wr_ack    <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
    end else if (model_en) begin
      if (!dut_rst_n) begin
        wp            <= '0;
        rp            <= '0;
        count         <= '0;
        exp_wr_ack    <= 1'b0;
        exp_overflow  <= 1'b0;
        exp_underflow <= 1'b0;
      end else begin
        exp_wr_ack    <= wr_acc;
        exp_overflow  <= wr_en && (count == DEPTH_C);
        exp_underflow <= rd_en && (count == '0);
        if (wr_acc) wp <= wp + PTR_W'(1);
        if (rd_acc) begin
          exp_data_out <= mem[rp];
          rp           <= rp + PTR_W'(1);
        end
        count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      correct_count <= '0;
      error_count   <= '0;
      err_valid     <= 1'b0;
      err_flags     <= '0;
    end else begin
      err_valid <= scored && (mismatch != '0);
      if (scored) begin
        err_flags <= mismatch;
        if (mismatch != '0) begin
          if (error_count != '1) error_count <= error_count + CNT_WIDTH'(1);
        end else if (correct_count != '1) begin
          correct_count <= correct_count + CNT_WIDTH'(1);
        end
      end
      case (state)
        IDLE: if (dut_rst_n) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (test_done) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [CNT_WIDTH-1:0] cycle_cnt;

  // first_err_cycle is the zero-based index of the scored cycle that first mismatched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt       <= '0;
      first_err_cycle <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      first_err_flags <= '0;
      first_err_valid <= 1'b0;
    end else if (scored) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if ((mismatch != '0) && !first_err_valid) begin
        first_err_cycle <= cycle_cnt;
        first_err_exp   <= exp_data_out;
        first_err_act   <= data_out;
        first_err_flags <= mismatch;
        first_err_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_checker.sv
// tb_fifo_stream_checker: the bench plays a queue-modelled FIFO, injects pin faults on chosen
// cycles and predicts the checker's scores from which pins it corrupted.
module tb_fifo_stream_checker;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 5;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0, dut_rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, test_done = 1'b0;
  logic [DW-1:0] data_in = '0, data_out = '0;
  logic          full = 1'b0, almostfull = 1'b0, empty = 1'b1, almostempty = 1'b0;
  logic          overflow = 1'b0, underflow = 1'b0, wr_ack = 1'b0;
  logic [CW-1:0] correct_count, error_count;
  logic          err_valid, done, busy;
  logic [7:0]    err_flags;
`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [CW-1:0] first_err_cycle;
  logic [DW-1:0] first_err_exp, first_err_act;
  logic [7:0]    first_err_flags;
  logic          first_err_valid;
`endif

  always #5 clk = ~clk;

  fifo_stream_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .dut_rst_n(dut_rst_n),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
    .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
    .overflow(overflow), .underflow(underflow), .wr_ack(wr_ack), .test_done(test_done),
    .correct_count(correct_count), .error_count(error_count), .err_valid(err_valid),
    .err_flags(err_flags), .done(done),
`ifdef FIFO_CHK_FIRST_ERR_EN
    .first_err_cycle(first_err_cycle), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act), .first_err_flags(first_err_flags),
    .first_err_valid(first_err_valid),
`endif
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference FIFO seen on the pins, and the scoreboard's expected results.
  typedef enum {S_IDLE, S_RUN, S_DONE} phase_t;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ack, m_ovf, m_udf;
  phase_t        ph;
  int            e_correct, e_error;
  logic          e_ev;
  logic [7:0]    e_ef;
  int            e_cyc;
  logic          e_fv;
  logic [DW-1:0] e_fexp, e_fact;
  logic [7:0]    e_fflags;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    q.delete();
    m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    ph = S_IDLE; e_correct = 0; e_error = 0; e_ev = 1'b0; e_ef = '0;
    e_cyc = 0; e_fv = 1'b0; e_fexp = '0; e_fact = '0; e_fflags = '0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; sample_en = 1'b0; test_done = 1'b0; dut_rst_n = 1'b0;
    #1;
    check("rst_correct_count", 32'(correct_count), 0);
    check("rst_error_count", 32'(error_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_valid", 32'(err_valid), 0);
    check("rst_err_flags", 32'(err_flags), 0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din,
                      input logic se, input logic drst, input logic td,
                      input logic [7:0] inj, input logic [DW-1:0] dxor);
    logic          scored;
    logic [DW-1:0] drv;
    int            sz;
    @(negedge clk);
    sz = q.size();
    wr_en = wr; rd_en = rd; data_in = din; sample_en = se; dut_rst_n = drst; test_done = td;
    drv = m_dout ^ (inj[0] ? dxor : '0);
    data_out    = drv;
    full        = (sz == DEPTH) ^ inj[1];
    almostfull  = (sz == DEPTH - 1) ^ inj[2];
    empty       = (sz == 0) ^ inj[3];
    almostempty = (sz == 1) ^ inj[4];
    overflow    = m_ovf ^ inj[5];
    underflow   = m_udf ^ inj[6];
    wr_ack      = m_ack ^ inj[7];
    @(posedge clk);
    scored = (ph == S_RUN) && se && drst;
    e_ev = 1'b0;
    if (scored) begin
      e_ef = inj;
      if (inj != 0) begin
        e_ev = 1'b1;
        if (e_error < SATV) e_error++;
        if (!e_fv) begin
          e_fv = 1'b1; e_fexp = m_dout; e_fact = drv; e_fflags = inj;
          e_fexp = m_dout;
        end
        if (e_fv && e_fflags == inj && e_fact == drv && e_fexp == m_dout && e_cyc >= 0) ;
      end else if (e_correct < SATV) begin
        e_correct++;
      end
    end
    if (scored && inj != 0 && e_fflags == inj && !(e_cyc < 0)) ;
    if (scored) begin
      if (e_fv && e_ev && e_error == 1 && e_fexp == m_dout) ;
    end
    if (ph == S_IDLE && drst) ph = S_RUN;
    else if (ph == S_RUN && td) ph = S_DONE;
    if (!drst) begin
      q.delete();
      m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_ovf = wr && (sz == DEPTH);
      m_udf = rd && (sz == 0);
      m_ack = wr && (sz < DEPTH);
      if (rd && sz > 0) m_dout = q.pop_front();
      if (wr && sz < DEPTH) q.push_back(din);
    end
    #1;
    check("correct_count", 32'(correct_count), 32'(e_correct));
    check("error_count", 32'(error_count), 32'(e_error));
    check("err_valid", 32'(err_valid), 32'(e_ev));
    check("err_flags", 32'(err_flags), 32'(e_ef));
    check("busy", 32'(busy), 32'(ph == S_RUN));
    check("done", 32'(done), 32'(ph == S_DONE));
  endtask

  // First-error bookkeeping kept apart so the capture index is taken before the increment.
  int first_cyc_latch;
  task automatic op(input logic wr, input logic rd, input logic [DW-1:0] din = '0,
                    input logic [7:0] inj = '0, input logic [DW-1:0] dxor = '0);
    logic will_score;
    will_score = (ph == S_RUN);
    if (will_score && inj != 0 && !e_fv) first_cyc_latch = e_cyc;
    step(wr, rd, din, 1'b1, 1'b1, 1'b0, inj, dxor);
    if (will_score && e_cyc < SATV) e_cyc++;
`ifdef FIFO_CHK_FIRST_ERR_EN
    check("first_err_valid", 32'(first_err_valid), 32'(e_fv));
    if (e_fv) begin
      check("first_err_cycle", 32'(first_err_cycle), 32'(first_cyc_latch));
      check("first_err_exp", 32'(first_err_exp), 32'(e_fexp));
      check("first_err_act", 32'(first_err_act), 32'(e_fact));
      check("first_err_flags", 32'(first_err_flags), 32'(e_fflags));
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]    inj;
    logic [DW-1:0] dx;
    first_cyc_latch = 0;
    clear_model();
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Fill with 1..8 then drain in order: sixteen clean scored cycles.
    for (int i = 1; i <= DEPTH; i++) op(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1);
    check("t2_correct16", 32'(correct_count), 16);
    check("t2_error0", 32'(error_count), 0);

    // Underflow on empty, overflow on full, both scored correct.
    op(1'b0, 1'b1);
    op(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'(16'h100 + i));
    op(1'b1, 1'b0, 16'hBEEF);
    op(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1);

    // Simultaneous read/write at count 4 and at count 0.
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, DW'(16'h200 + i));
    op(1'b1, 1'b1, 16'h0055);
    op(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1);
    op(1'b1, 1'b1, 16'h0077);
    op(1'b0, 1'b0);
    op(1'b0, 1'b1);
    op(1'b0, 1'b0);
    check("t4_no_errors", 32'(error_count), 0);

    // Mid-run checker reset, then a corrupted data_out where 0x0003 is due.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 1; i <= DEPTH; i++) op(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1);
    op(1'b0, 1'b0, '0, 8'h01, 16'h0003 ^ 16'hDEAD);
    check("t5_err_valid", 32'(err_valid), 1);
    check("t5_err_flags", 32'(err_flags), 32'h01);
    check("t5_error_count", 32'(error_count), 1);
`ifdef FIFO_CHK_FIRST_ERR_EN
    check("t5_first_exp", 32'(first_err_exp), 32'h0003);
    check("t5_first_act", 32'(first_err_act), 32'hDEAD);
`endif
    op(1'b0, 1'b0);

    // FIFO reset at count 5, then test_done and frozen counters.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    op(1'b0, 1'b0);
    op(1'b1, 1'b0, 16'h0042);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, '0, '0);
    check("t6_done", 32'(done), 1);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b1, DW'(i), 8'h81, '0);

    // Randomised traffic with occasional FIFO resets and pin faults; counters saturate.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 500; i++) begin
      inj = '0; dx = '0;
      if ($urandom_range(0, 19) == 0) begin
        inj = 8'($urandom_range(1, 255));
        dx  = 16'($urandom_range(1, 65535));
      end
      if ($urandom_range(0, 32) == 0)
        step(1'($urandom), 1'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0, '0, '0);
      else if ($urandom_range(0, 4) == 0)
        step(1'($urandom), 1'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, inj, dx);
      else
        op(1'($urandom), 1'($urandom), 16'($urandom), inj, dx);
    end
    check("rand_correct_sat", 32'(correct_count), 32'(SATV));
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, '0, '0);
    op(1'b1, 1'b0, 16'h1234, 8'h02, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
